// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer path.
// Holds the frame geometry, the fragment address width shared with
// line_drawing, the packed {r,g,b} pixel type and the store FSM encoding.
package fb_pkg;

  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int DEPTH  = FB_W * FB_H;
  localparam int ADDR_W = 17;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/fb_ram_1w1r.sv
// Simple dual-port pixel RAM: one write port, one synchronous read port.
// A read and a write to the same address on the same edge return the old
// contents. No reset; contents are undefined until written.
// Ports:
//   clk   - clock
//   we    - write enable, waddr/wdata written on the rising edge
//   re    - read enable, rdata updated from raddr on the rising edge
module fb_ram_1w1r #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 76800,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fb_pixel_store.sv
// Frame-buffer storage stage behind line_drawing.
// Captures fragment writes into an FB_W x FB_H 3-bit pixel RAM, offers a
// full-frame clear sweep and a valid/ready dump stream in address order.
// Ports:
//   clk, reset_n                  - clock, asynchronous active-low reset
//   fb_we, fb_addr, red/green/blue_in - fragment write (never stalled)
//   clear_start, clear_rgb        - start a clear sweep with the given colour
//   dump_start                    - start streaming all pixels
//   rd_ready / rd_valid, rd_addr, rd_rgb, rd_last - dump stream
//   busy                          - a clear or dump is in progress
//   done                          - one-cycle pulse when a clear/dump ends
//   err_oob                       - sticky: an out-of-range fragment was dropped
module fb_pixel_store #(
  parameter int FB_W = fb_pkg::FB_W,
  parameter int FB_H = fb_pkg::FB_H
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fb_we,
  input  logic [16:0] fb_addr,
  input  logic        red_in,
  input  logic        green_in,
  input  logic        blue_in,
  input  logic        clear_start,
  input  logic [2:0]  clear_rgb,
  input  logic        dump_start,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [16:0] rd_addr,
  output logic [2:0]  rd_rgb,
  output logic        rd_last,
  output logic        busy,
  output logic        done,
  output logic        err_oob
);

  import fb_pkg::*;

  localparam int    DEPTH = FB_W * FB_H;
  localparam int    IDX_W = $clog2(DEPTH);
  localparam addr_t LAST  = addr_t'(DEPTH - 1);

  state_t state;
  addr_t  cptr;
  addr_t  rptr;
  logic   hold_skip;
  rgb_t   clr_rgb;
  rgb_t   frag_rgb;

  logic   frag_ok;
  logic   frag_oob;
  logic   start_clear;
  logic   clr_wr;
  logic   pop;
  logic   head_free;
  logic [1:0] occ;
  logic   issue_p0;

  logic   vld_p1;
  addr_t  addr_p1;
  logic [2:0] rgb_p1;
  logic   last_p1;

  logic   skid_vld;
  addr_t  skid_addr;
  logic [2:0] skid_rgb;
  logic   skid_last;

  assign frag_rgb    = '{r: red_in, g: green_in, b: blue_in};
  assign frag_ok     = fb_we && (fb_addr <= LAST);
  assign frag_oob    = fb_we && (fb_addr > LAST);
  assign start_clear = (state == ST_IDLE) && clear_start;
  // A fragment owns the write port. hold_skip marks that the fragment landed
  // exactly on cptr, so that pixel is stepped over instead of cleared.
  assign clr_wr      = (state == ST_CLEAR) && !frag_ok && !hold_skip;

  assign busy        = (state != ST_IDLE);
  assign pop         = rd_valid && rd_ready;
  assign head_free   = pop || !rd_valid;
  // Entries held or in flight after this edge; a new read needs one free slot.
  assign occ         = 2'(rd_valid) + 2'(skid_vld) + 2'(vld_p1) - 2'(pop);
  assign issue_p0    = (state == ST_DUMP) && (occ < 2'd2);
  assign last_p1     = (addr_p1 == LAST);

  fb_ram_1w1r #(
    .DATA_W ($bits(rgb_t)),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk    (clk),
    .we     (frag_ok || clr_wr),
    .waddr  (frag_ok ? fb_addr[IDX_W-1:0] : cptr[IDX_W-1:0]),
    .wdata  (frag_ok ? frag_rgb : clr_rgb),
    .re     (issue_p0),
    .raddr  (rptr[IDX_W-1:0]),
    .rdata  (rgb_p1)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cptr      <= '0;
      rptr      <= '0;
      hold_skip <= 1'b0;
      done      <= 1'b0;
      err_oob   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_clear) begin
        err_oob <= 1'b0;
      end
      if (frag_oob) begin
        err_oob <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state     <= ST_CLEAR;
            cptr      <= '0;
            hold_skip <= 1'b0;
          end else if (dump_start) begin
            state <= ST_DUMP;
            rptr  <= '0;
          end
        end
        ST_CLEAR: begin
          if (frag_ok) begin
            if (fb_addr == cptr) begin
              hold_skip <= 1'b1;
            end
          end else begin
            hold_skip <= 1'b0;
            if (cptr == LAST) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              cptr <= cptr + addr_t'(1);
            end
          end
        end
        ST_DUMP: begin
          if (issue_p0) begin
            if (rptr == LAST) begin
              state <= ST_DRAIN;
            end else begin
              rptr <= rptr + addr_t'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pop && rd_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start_clear) begin
      clr_rgb <= rgb_t'(clear_rgb);
    end
  end

  // p0 -> p1: read issued at rptr, RAM data returns one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (issue_p0) begin
      addr_p1 <= rptr;
    end
  end

  // p1 -> output: returned pixel enters the 2-entry skid buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_addr  <= '0;
      rd_rgb   <= '0;
      rd_last  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (head_free) begin
      if (skid_vld) begin
        rd_valid <= 1'b1;
        rd_addr  <= skid_addr;
        rd_rgb   <= skid_rgb;
        rd_last  <= skid_last;
        skid_vld <= vld_p1;
      end else begin
        rd_valid <= vld_p1;
        if (vld_p1) begin
          rd_addr <= addr_p1;
          rd_rgb  <= rgb_p1;
          rd_last <= last_p1;
        end
      end
    end else if (vld_p1) begin
      skid_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1 && (skid_vld || !head_free)) begin
      skid_addr <= addr_p1;
      skid_rgb  <= rgb_p1;
      skid_last <= last_p1;
    end
  end

endmodule

// File: tb/tb_fb_pixel_store.sv
// Self-checking bench for fb_pixel_store on a reduced 20x12 frame.
module tb_fb_pixel_store;

  localparam int W     = 20;
  localparam int H     = 12;
  localparam int DEPTH = W * H;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fb_we = 1'b0;
  logic [16:0] fb_addr = '0;
  logic        red_in = 1'b0;
  logic        green_in = 1'b0;
  logic        blue_in = 1'b0;
  logic        clear_start = 1'b0;
  logic [2:0]  clear_rgb = '0;
  logic        dump_start = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [16:0] rd_addr;
  logic [2:0]  rd_rgb;
  logic        rd_last;
  logic        busy;
  logic        done;
  logic        err_oob;

  always #5 clk = ~clk;

  fb_pixel_store #(.FB_W(W), .FB_H(H)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .red_in      (red_in),
    .green_in    (green_in),
    .blue_in     (blue_in),
    .clear_start (clear_start),
    .clear_rgb   (clear_rgb),
    .dump_start  (dump_start),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_addr     (rd_addr),
    .rd_rgb      (rd_rgb),
    .rd_last     (rd_last),
    .busy        (busy),
    .done        (done),
    .err_oob     (err_oob)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame contents, sticky error, operation timing.
  logic [2:0] mem_m [DEPTH];
  logic [2:0] cap   [DEPTH];
  bit m_busy = 0, m_done = 0, m_err = 0, m_dump = 0;
  int m_clr_left = 0;
  int m_next = 0;
  int beats = 0;

  always @(posedge clk or negedge reset_n) begin
    bit was_busy;
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_err = 0; m_dump = 0;
      m_clr_left = 0; m_next = 0; beats = 0;
    end else begin
      was_busy = m_busy;
      m_done = 0;
      if (m_dump && rd_valid && rd_ready) begin
        if (m_next < DEPTH) cap[m_next] = rd_rgb;
        m_next++;
        beats++;
        if (m_next == DEPTH) begin
          m_dump = 0; m_busy = 0; m_done = 1;
        end
      end
      if (was_busy && !m_dump && m_clr_left > 0) begin
        if (!(fb_we && fb_addr < DEPTH)) begin
          m_clr_left--;
          if (m_clr_left == 0) begin
            m_busy = 0; m_done = 1;
          end
        end
      end
      if (fb_we && fb_addr < DEPTH) mem_m[fb_addr] = {red_in, green_in, blue_in};
      if (!was_busy && clear_start) begin
        m_busy = 1; m_clr_left = DEPTH; m_err = 0;
        foreach (mem_m[i]) mem_m[i] = clear_rgb;
      end else if (!was_busy && dump_start) begin
        m_busy = 1; m_dump = 1; m_next = 0; beats = 0;
      end
      if (fb_we && fb_addr >= DEPTH) m_err = 1;
    end
  end

  // Compare process: every falling edge.
  bit stall_prev = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_valid", rd_valid, 0);
      check("rst_addr", rd_addr, 0);
      check("rst_rgb", rd_rgb, 0);
      check("rst_last", rd_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err_oob, 0);
    end else begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("err_oob", err_oob, m_err);
      if (!m_dump) begin
        check("idle_valid", rd_valid, 0);
      end else if (rd_valid && m_next < DEPTH) begin
        check("beat_addr", rd_addr, m_next);
        check("beat_rgb", rd_rgb, mem_m[m_next]);
        check("beat_last", rd_last, (m_next == DEPTH - 1));
      end
      if (stall_prev) check("stall_hold", rd_valid, 1);
    end
    stall_prev = reset_n && rd_valid && !rd_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frag(input int addr, input logic [2:0] c);
    fb_we = 1'b1;
    fb_addr = 17'(addr);
    {red_in, green_in, blue_in} = c;
    tick();
    fb_we = 1'b0;
  endtask

  // Clear; optional fragments driven in the exact cycle the sweep reaches ha/hb.
  task automatic run_clear(input logic [2:0] col, input bit with_dump, input int ha,
                           input int hb, input logic [2:0] hc, output int edges);
    int pos;
    bit ua, ub, hit;
    clear_rgb = col;
    clear_start = 1'b1;
    dump_start = with_dump;
    tick();
    clear_start = 1'b0;
    dump_start = 1'b0;
    pos = 0; ua = 0; ub = 0; edges = -1;
    for (int e = 0; e < 2 * DEPTH; e++) begin
      if (done) begin
        edges = e;
        break;
      end
      hit = 0;
      if (!ua && pos == ha) begin hit = 1; ua = 1; end
      else if (!ub && pos == hb) begin hit = 1; ub = 1; end
      fb_we = hit;
      fb_addr = 17'(pos);
      {red_in, green_in, blue_in} = hc;
      tick();
      fb_we = 1'b0;
      if (!hit) pos++;
    end
  endtask

  // Dump; mode 0 holds rd_ready high, mode 1 toggles 1,0,0,1. abort_at >= 0
  // pulses reset_n low for one cycle once that many beats have transferred.
  task automatic run_dump(input int mode, input int abort_at, output int first, output int edges);
    logic [3:0] pat;
    int e;
    pat = 4'b1001;
    first = -1; edges = -1;
    rd_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    e = 0;
    while (e < 8 * DEPTH) begin
      if (first < 0 && rd_valid) first = e;
      if (done) begin
        edges = e;
        break;
      end
      if (abort_at >= 0 && beats == abort_at) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        edges = e;
        return;
      end
      rd_ready = (mode == 0) ? 1'b1 : pat[e % 4];
      tick();
      e++;
    end
    rd_ready = 1'b1;
    if (edges < 0) check("dump_timeout", 0, 1);
  endtask

  initial begin
    int ed, fv;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("init_valid", rd_valid, 0);
    check("init_busy", busy, 0);
    check("init_err", err_oob, 0);

    // Plain clear to black, then full-rate dump.
    run_clear(3'b000, 1'b0, -1, -1, 3'b000, ed);
    check("clear_cycles", ed, 240);
    run_dump(0, -1, fv, ed);
    check("dump_first_valid", fv, 2);
    check("dump_cycles", ed, 242);
    check("dump_beats", beats, 240);
    check("dump_px0", cap[0], 0);
    check("dump_px239", cap[239], 0);

    // Diagonal green line x=y=0..11 after a clear.
    run_clear(3'b000, 1'b0, -1, -1, 3'b000, ed);
    for (int i = 0; i < H; i++) frag(i * W + i, 3'b010);
    tick();
    run_dump(0, -1, fv, ed);
    check("diag_beats", beats, 240);
    check("diag_px0", cap[0], 3'b010);
    check("diag_px21", cap[21], 3'b010);
    check("diag_px231", cap[231], 3'b010);
    check("diag_px1", cap[1], 3'b000);
    check("diag_px20", cap[20], 3'b000);

    // Fragments colliding with the sweep at 5 and the last address.
    run_clear(3'b111, 1'b0, 5, DEPTH - 1, 3'b100, ed);
    check("collide_cycles", ed, 242);
    run_dump(1, -1, fv, ed);
    check("toggle_first_valid", fv, 2);
    check("toggle_beats", beats, 240);
    check("collide_px5", cap[5], 3'b100);
    check("collide_px239", cap[239], 3'b100);
    check("collide_px6", cap[6], 3'b111);
    check("collide_px4", cap[4], 3'b111);

    // Out-of-range fragment: dropped, sticky error until the next clear.
    frag(DEPTH, 3'b001);
    tick();
    check("oob_err_set", err_oob, 1);
    run_dump(0, -1, fv, ed);
    check("oob_err_after_dump", err_oob, 1);
    check("oob_px0", cap[0], 3'b111);
    check("oob_px5", cap[5], 3'b100);
    // Simultaneous clear and dump start: clear wins.
    run_clear(3'b011, 1'b1, -1, -1, 3'b000, ed);
    check("both_start_cycles", ed, 240);
    check("oob_err_cleared", err_oob, 0);

    // Reset in the middle of a dump, then restart from address 0.
    run_dump(1, 100, fv, ed);
    check("abort_valid", rd_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_addr", rd_addr, 0);
    repeat (4) tick();
    run_dump(0, -1, fv, ed);
    check("restart_first_valid", fv, 2);
    check("restart_cycles", ed, 242);
    check("restart_beats", beats, 240);
    check("restart_px0", cap[0], 3'b011);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
